// File: rtl/interval_timer_bank.sv
// Bank of independent programmable interval timers sharing one prescale value and one config write port.
// Each channel counts prescaled strobes to its period, then pulses tick and reloads or stops.
module interval_timer_bank #(
   parameter int unsigned WIDTH    = 28,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned PRE_W    = 8,
   parameter int unsigned CH_W     = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [WIDTH-1:0]    cfg_period,
   input  logic                cfg_periodic,
   input  logic [PRE_W-1:0]    prescale,
   input  logic [CHANNELS-1:0] start,
   input  logic [CHANNELS-1:0] stop,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] running,
   output logic                any_tick
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              r_state     [CHANNELS];
   state_t              w_state_nxt [CHANNELS];
   logic [WIDTH-1:0]    r_period    [CHANNELS];
   logic                r_mode      [CHANNELS];
   logic [WIDTH-1:0]    r_cnt       [CHANNELS];
   logic [WIDTH-1:0]    w_cnt_nxt   [CHANNELS];
   logic [PRE_W-1:0]    r_pre       [CHANNELS];
   logic [PRE_W-1:0]    w_pre_nxt   [CHANNELS];
   logic [CHANNELS-1:0] w_cfg_hit;
   logic [CHANNELS-1:0] w_tick_nxt;
   logic [CHANNELS-1:0] r_tick;
   logic                r_any_tick;

   // Next-state and counter update per channel: stop > start > counting.
   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         w_pre_nxt[i]   = r_pre[i];
         w_tick_nxt[i]  = 1'b0;
         w_cfg_hit[i]   = cfg_we && (cfg_chan == CH_W'(i));

         if (stop[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
            w_pre_nxt[i]   = '0;
         end else if (start[i]) begin
            w_state_nxt[i] = ST_RUN;
            w_cnt_nxt[i]   = '0;
            w_pre_nxt[i]   = '0;
         end else if (r_state[i] == ST_RUN) begin
            if (r_pre[i] != prescale) begin
               w_pre_nxt[i] = r_pre[i] + PRE_W'(1);
            end else begin
               w_pre_nxt[i] = '0;
               // >= so a period shrunk below cnt terminates instead of wrapping
               if (r_cnt[i] >= r_period[i]) begin
                  w_tick_nxt[i] = 1'b1;
                  w_cnt_nxt[i]  = '0;
                  if (!r_mode[i]) begin
                     w_state_nxt[i] = ST_IDLE;
                  end
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
               end
            end
         end
      end
   end

   // State, counters, configuration and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_state[i]  <= ST_IDLE;
            r_period[i] <= '0;
            r_mode[i]   <= 1'b0;
            r_cnt[i]    <= '0;
            r_pre[i]    <= '0;
         end
         r_tick     <= '0;
         r_any_tick <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
            r_pre[i]   <= w_pre_nxt[i];
            if (w_cfg_hit[i]) begin
               r_period[i] <= cfg_period;
               r_mode[i]   <= cfg_periodic;
            end
         end
         r_tick     <= w_tick_nxt;
         r_any_tick <= |w_tick_nxt;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         running[i] = (r_state[i] == ST_RUN);
      end
   end

   assign tick     = r_tick;
   assign any_tick = r_any_tick;

endmodule

// File: tb/tb_interval_timer_bank.sv
// Randomized and directed stimulus for interval_timer_bank; a timestamp-based reference model
// predicts outputs per edge into a queue that a separate monitor drains and compares.
module tb_interval_timer_bank;

   localparam int unsigned WIDTH    = 28;
   localparam int unsigned CHANNELS = 4;
   localparam int unsigned PRE_W    = 8;
   localparam int unsigned CH_W     = 2;

   logic                clock;
   logic                reset;
   logic                cfg_we;
   logic [CH_W-1:0]     cfg_chan;
   logic [WIDTH-1:0]    cfg_period;
   logic                cfg_periodic;
   logic [PRE_W-1:0]    prescale;
   logic [CHANNELS-1:0] start;
   logic [CHANNELS-1:0] stop;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] running;
   logic                any_tick;

   interval_timer_bank #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRE_W(PRE_W), .CH_W(CH_W)
   ) dut (
      .clock(clock), .reset(reset),
      .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_period(cfg_period),
      .cfg_periodic(cfg_periodic), .prescale(prescale),
      .start(start), .stop(stop),
      .tick(tick), .running(running), .any_tick(any_tick)
   );

   typedef struct packed {
      logic [CHANNELS-1:0] tick;
      logic [CHANNELS-1:0] run;
      logic                any;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model state: an interval is described by the edge it began on, not by counters.
   bit     m_run    [CHANNELS];
   int     m_t0     [CHANNELS];
   longint m_period [CHANNELS];
   bit     m_mode   [CHANNELS];
   int     edge_n = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: one prediction per rising edge.
   initial begin
      forever begin
         exp_t e;
         @(posedge clock);
         edge_n++;
         e = '0;
         if (reset) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
               m_run[c] = 1'b0; m_t0[c] = 0; m_period[c] = 0; m_mode[c] = 1'b0;
            end
         end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
               if (stop[c]) begin
                  m_run[c] = 1'b0;
               end else if (start[c]) begin
                  m_run[c] = 1'b1;
                  m_t0[c]  = edge_n;
               end else if (m_run[c]) begin
                  int j;
                  int s1;
                  j  = edge_n - m_t0[c];
                  s1 = int'(prescale) + 1;
                  // strobe number n of this interval sees a count of n-1 strobes already taken
                  if ((j % s1 == 0) && (longint'(j / s1) - 1 >= m_period[c])) begin
                     e.tick[c] = 1'b1;
                     if (m_mode[c]) m_t0[c] = edge_n;
                     else           m_run[c] = 1'b0;
                  end
               end
               if (cfg_we && int'(cfg_chan) == c) begin
                  m_period[c] = longint'(cfg_period);
                  m_mode[c]   = cfg_periodic;
               end
               e.run[c] = m_run[c];
            end
         end
         e.any = |e.tick;
         exp_q.push_back(e);
      end
   end

   task automatic check(input string name, input logic [CHANNELS-1:0] act, input logic [CHANNELS-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare away from the active edge.
   initial begin
      forever begin
         exp_t e;
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick",     tick,                      e.tick);
            check("running",  running,                   e.run);
            check("any_tick", {{(CHANNELS-1){1'b0}}, any_tick}, {{(CHANNELS-1){1'b0}}, e.any});
         end
      end
   end

   task automatic next(input int n = 1);
      repeat (n) begin
         @(negedge clock);
         cfg_we = 1'b0;
         start  = '0;
         stop   = '0;
      end
   endtask

   task automatic cfg(input int ch, input int p, input bit per);
      cfg_we       = 1'b1;
      cfg_chan     = CH_W'(ch);
      cfg_period   = WIDTH'(p);
      cfg_periodic = per;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_period = '0;
      cfg_periodic = 1'b0; prescale = '0; start = '0; stop = '0;
      next(3);
      reset = 1'b0;

      // Idle after reset, then a config write without start.
      next(20);
      cfg(0, 4, 1'b1); next(); next(3);

      // Ch0 periodic P=4 S=0.
      prescale = 8'd0;
      start[0] = 1'b1; next(); next(30);

      // Ch1 one-shot P=2 S=3.
      do_reset();
      prescale = 8'd3;
      cfg(1, 2, 1'b0); next();
      start[1] = 1'b1; next(); next(25);

      // Ch2 periodic P=10, period shrunk to 3 while cnt is 7; cfg and start share an edge.
      do_reset();
      prescale = 8'd0;
      cfg(2, 10, 1'b1); start[2] = 1'b1; next();
      next(7);
      cfg(2, 3, 1'b1); next();
      next(20);

      // Stop+start on a terminal edge, then start alone on a terminal edge.
      do_reset();
      prescale = 8'd0;
      cfg(0, 4, 1'b1); next();
      start[0] = 1'b1; next(); next(4);
      stop[0] = 1'b1; start[0] = 1'b1; next(); next(5);
      start[0] = 1'b1; next(); next(4);
      start[0] = 1'b1; next(); next(12);

      // All channels periodic P=0..3 S=1, then reset mid-run.
      do_reset();
      prescale = 8'd1;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         cfg(c, c, 1'b1); next();
      end
      start = '1; next(); next(40);
      reset = 1'b1; next(); reset = 1'b0; next(5);

      // Randomized segments with constant prescale per segment.
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         prescale = PRE_W'($urandom_range(0, 3));
         for (int cy = 0; cy < 300; cy++) begin
            if ($urandom_range(0, 7) == 0) begin
               cfg(int'($urandom_range(0, CHANNELS - 1)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
            end
            for (int c = 0; c < int'(CHANNELS); c++) begin
               start[c] = ($urandom_range(0, 15) == 0);
               stop[c]  = ($urandom_range(0, 31) == 0);
            end
            next();
         end
      end

      next(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/interval_timer_bank.md
# interval_timer_bank

Bank of CHANNELS independent programmable interval timers. It is the parametrised successor to the single fixed-width cycle counter. Each channel counts prescaled clock strobes up to a programmed terminal value. On reaching it, the channel emits a one-cycle tick, then either reloads (periodic mode) or stops (one-shot mode). The bank sits beside the control FSMs and supplies their delay and heartbeat events; channels are configured through a shared write port.

## Interface
Parameters:
- WIDTH, 28, width of each channel's period register and counter
- CHANNELS, 4, number of independent timer channels (1..16)
- PRE_W, 8, width of the shared prescale value
- CH_W, 2, width of the channel select (must satisfy 2^CH_W >= CHANNELS)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clock clock
- cfg_we  in  1  write strobe for channel configuration
- cfg_chan  in  CH_W  channel addressed by cfg_we
- cfg_period  in  WIDTH  terminal count P written to the addressed channel
- cfg_periodic  in  1  mode written to the addressed channel: 1 = periodic, 0 = one-shot
- prescale  in  PRE_W  shared prescale S; a channel advances once per S+1 clocks
- start  in  CHANNELS  per-channel start/restart request, level sampled each edge
- stop  in  CHANNELS  per-channel abort request
- tick  out  CHANNELS  one-cycle pulse per channel on terminal count
- running  out  CHANNELS  channel is in the RUN state
- any_tick  out  1  registered OR of all channels' tick conditions, aligned with tick

## Operation
- Reset values:
  - tick, running and any_tick are 0.
  - All period registers are 0, all modes are one-shot, and all counters and prescale counters are 0.
- Each channel has two states, IDLE and RUN, and holds these registers: period (WIDTH), mode (1), cnt (WIDTH), pre (PRE_W).
- Configuration:
  - When cfg_we is high, the period and mode of channel cfg_chan are written at the edge.
  - A cfg_chan value of CHANNELS or above is ignored.
  - Writes are legal in either state and take effect at the next edge; a running channel is not restarted.
- Per-channel priority at each edge: stop > start > normal counting.
  - stop: state goes to IDLE, cnt and pre are cleared, no tick is issued.
  - start (in any state): state goes to RUN, cnt and pre are cleared. A start during RUN restarts the interval.
  - RUN with pre != S: pre increments.
  - RUN with pre == S: this is a strobe. pre is cleared.
    - If cnt >= period: tick is set for one cycle. In periodic mode cnt is cleared and the channel stays in RUN. In one-shot mode the channel goes to IDLE and cnt is cleared.
    - Otherwise cnt increments.
- The compare uses >=, not ==. A period shrunk below the current cnt therefore terminates at the next strobe instead of wrapping through 2^WIDTH. cnt never wraps.
- Period 0 gives a tick on every strobe.
- tick is 0 on every edge where the channel is not terminating.
- A channel in IDLE holds cnt and pre at 0 and ignores the prescale value.
- Changing prescale mid-run applies from the next compare. If pre > S, pre counts on and wraps modulo 2^PRE_W before strobing; the bench exercises only S values that do not do this.

## Timing
- A start sampled at edge k gives the first tick high during the cycle after edge k + (P+1)(S+1).
- In periodic mode, ticks are spaced exactly (P+1)(S+1) cycles apart, with no slip on reload.
- running rises the cycle after the start edge.
- In one-shot mode, running falls at the same edge tick rises.
- stop or reset during RUN: running and tick are low from the next cycle. A pending terminal strobe on that same edge is suppressed.
- start and stop asserted together: stop wins, and the channel ends in IDLE.
- start asserted on the same edge as a terminal strobe: the restart wins, tick is not issued, and the counters are cleared.
- A cfg write and a start on the same edge: the start clears the counters, and the new period governs the fresh interval.
- any_tick is high in exactly the cycles where any tick bit is high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle for 20 cycles -> tick, running and any_tick all 0; running[0] = 0 after a cfg write with no start.
- Ch0: P=4, S=0, periodic, start at edge 10 -> tick[0] high in the cycles after edges 15, 20, 25, …, single-cycle each; running[0] stays 1.
- Ch1: P=2, S=3, one-shot, start at edge 5 -> tick[1] high only in the cycle after edge 17; running[1] falls at edge 17 and no further ticks occur.
- Ch2: P=10 periodic, S=0; at cnt=7 write P=3 -> tick at the next edge (7 >= 3), then period 4.
- Ch0 running with P=4, S=0; assert stop and start together at the edge where cnt=4 -> no tick, running[0] = 0. Separately, start alone at that edge -> no tick, next tick 5 cycles later.
- All channels: P=0, 1, 2, 3, S=1, periodic, started together -> tick periods of 2, 4, 6 and 8 cycles; any_tick equals the OR of the tick bits every cycle. A reset mid-run clears everything within 1 cycle.
